// File: rtl/fib_seq_engine.sv
// ============================================================================
// Module   : fib_seq_engine
// Purpose  : Generalised Fibonacci term generator (single-term or streaming).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fib_seq_engine #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 8,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] n,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic             stream,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             overflow,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_k;
    logic [IDX_W-1:0] r_n;
    logic             r_b_ovf;
    logic             r_ovf;
    logic             r_valid;
    logic             r_done;

    logic [WIDTH:0]   w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_next;
    logic             w_more;
    logic             w_last;

    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_carry = w_sum[WIDTH];
    assign w_next  = ((SAT != 0) && w_carry) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    assign w_more  = (r_k < r_n);
    assign w_last  = (r_k == r_n);

    // r_b runs one term ahead of the presented term, so its carry is held in
    // r_b_ovf and only folded into the sticky flag when that term reaches r_a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_n     <= '0;
            r_b_ovf <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= seed0;
                        r_b     <= seed1;
                        r_k     <= '0;
                        r_n     <= n;
                        r_b_ovf <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= stream ? S_EMIT : S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_more) begin
                        r_a     <= r_b;
                        r_b     <= w_next;
                        r_k     <= r_k + 1'b1;
                        r_ovf   <= r_ovf | r_b_ovf;
                        r_b_ovf <= w_carry;
                    end else begin
                        r_valid <= 1'b1;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                    end else if (out_ready) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_a     <= r_b;
                            r_b     <= w_next;
                            r_k     <= r_k + 1'b1;
                            r_ovf   <= r_ovf | r_b_ovf;
                            r_b_ovf <= w_carry;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_valid;
    assign out_data  = r_a;
    assign out_idx   = r_k;
    assign out_last  = r_valid & w_last;
    assign overflow  = r_ovf;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_fib_seq_engine.sv
// ============================================================================
// Module   : tb_fib_seq_engine
// Purpose  : Directed self-checking bench for fib_seq_engine (wrap and sat).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fib_seq_engine;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] n;
    logic [7:0] seed0;
    logic [7:0] seed1;
    logic       stream;
    logic       out_ready;

    logic       busy, out_valid, out_last, overflow, done;
    logic [7:0] out_data, out_idx;
    logic       busy_s, valid_s, last_s, ovf_s, done_s;
    logic [7:0] data_s, idx_s;

    int n_chk  = 0;
    int n_pass = 0;

    fib_seq_engine #(.WIDTH(8), .IDX_W(8), .SAT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n(n), .seed0(seed0),
        .seed1(seed1), .stream(stream), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .overflow(overflow), .done(done)
    );

    fib_seq_engine #(.WIDTH(8), .IDX_W(8), .SAT(1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .n(n), .seed0(seed0),
        .seed1(seed1), .stream(stream), .busy(busy_s), .out_valid(valid_s),
        .out_ready(out_ready), .out_data(data_s), .out_idx(idx_s),
        .out_last(last_s), .overflow(ovf_s), .done(done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [7:0] nn, input logic [7:0] s0,
                      input logic [7:0] s1, input logic st);
        n = nn; seed0 = s0; seed1 = s1; stream = st; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int c);
        c = 0;
        while (!out_valid && c < 500) begin
            tick();
            c++;
        end
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (!done && c < 500) begin
            tick();
            c++;
        end
        chk(tag, 32'(done), 1);
    endtask

    int c;
    int got;
    int e2[6] = '{2, 1, 3, 4, 7, 11};
    int fib[9] = '{0, 1, 1, 2, 3, 5, 8, 13, 21};

    initial begin
        rst_n = 1'b0; start = 1'b0; n = '0; seed0 = '0; seed1 = '0;
        stream = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_busy",  32'(busy), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data",  32'(out_data), 0);
        chk("rst_idx",   32'(out_idx), 0);
        chk("rst_last",  32'(out_last), 0);
        chk("rst_ovf",   32'(overflow), 0);
        chk("rst_done",  32'(done), 0);
        #20 rst_n = 1'b1;
        tick();

        // single mode, F(10)
        go(8'd10, 8'd0, 8'd1, 1'b0);
        chk("t1_busy", 32'(busy), 1);
        wait_valid(c);
        chk("t1_lat",  32'(c), 11);
        chk("t1_data", 32'(out_data), 55);
        chk("t1_idx",  32'(out_idx), 10);
        chk("t1_last", 32'(out_last), 1);
        tick();
        chk("t1_done",  32'(done), 1);
        chk("t1_vdrop", 32'(out_valid), 0);
        chk("t1_idle",  32'(busy), 0);
        tick();
        chk("t1_pulse", 32'(done), 0);

        // stream mode, seeds 2,1
        go(8'd5, 8'd2, 8'd1, 1'b1);
        wait_valid(c);
        chk("t2_lat", 32'(c), 1);
        for (int i = 0; i < 6; i++) begin
            chk("t2_valid", 32'(out_valid), 1);
            chk("t2_data",  32'(out_data), 32'(e2[i]));
            chk("t2_idx",   32'(out_idx), 32'(i));
            chk("t2_last",  32'(out_last), (i == 5) ? 1 : 0);
            tick();
        end
        chk("t2_done", 32'(done), 1);
        tick();

        // stream mode with random back-pressure
        go(8'd8, 8'd0, 8'd1, 1'b1);
        got = 0;
        for (int cyc = 0; cyc < 300 && got < 9; cyc++) begin
            if (out_valid) begin
                chk("t3_data", 32'(out_data), 32'(fib[got]));
                chk("t3_idx",  32'(out_idx), 32'(got));
                out_ready = 1'($urandom_range(0, 1));
                if (out_ready) got++;
            end
            tick();
        end
        out_ready = 1'b1;
        chk("t3_count", 32'(got), 9);
        chk("t3_done",  32'(done), 1);
        tick();

        // width boundary, wrap vs saturate
        go(8'd13, 8'd0, 8'd1, 1'b0);
        wait_valid(c);
        chk("t4_f13",     32'(out_data), 233);
        chk("t4_f13_ovf", 32'(overflow), 0);
        chk("t4_f13_sat", 32'(data_s), 233);
        chk("t4_f13_so",  32'(ovf_s), 0);
        wait_done("t4_done13");
        tick();
        go(8'd14, 8'd0, 8'd1, 1'b0);
        wait_valid(c);
        chk("t4_f14_wrap", 32'(out_data), 121);
        chk("t4_f14_ovf",  32'(overflow), 1);
        chk("t4_f14_sat",  32'(data_s), 255);
        chk("t4_f14_so",   32'(ovf_s), 1);
        wait_done("t4_done14");
        tick();

        // n = 0 in both modes
        for (int m = 0; m < 2; m++) begin
            go(8'd0, 8'd77, 8'd5, 1'(m));
            wait_valid(c);
            chk("t5_lat",  32'(c), 1);
            chk("t5_data", 32'(out_data), 77);
            chk("t5_idx",  32'(out_idx), 0);
            chk("t5_last", 32'(out_last), 1);
            tick();
            chk("t5_done", 32'(done), 1);
            chk("t5_one",  32'(out_valid), 0);
        end

        // start while busy is ignored
        go(8'd6, 8'd0, 8'd1, 1'b0);
        n = 8'd2; seed0 = 8'd9; seed1 = 8'd9; stream = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(c);
        chk("t6_lat",  32'(c + 1), 7);
        chk("t6_data", 32'(out_data), 8);
        chk("t6_idx",  32'(out_idx), 6);
        wait_done("t6_done");
        tick();

        // largest index completes without wrap
        go(8'd255, 8'd0, 8'd1, 1'b0);
        wait_valid(c);
        chk("t7_lat",  32'(c), 256);
        chk("t7_idx",  32'(out_idx), 255);
        chk("t7_last", 32'(out_last), 1);
        chk("t7_ovf",  32'(overflow), 1);
        wait_done("t7_done");
        tick();

        // asynchronous reset during stream beat 3
        go(8'd8, 8'd0, 8'd1, 1'b1);
        wait_valid(c);
        tick(); tick(); tick();
        chk("t8_beat3", 32'(out_idx), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t8_busy",  32'(busy), 0);
        chk("t8_valid", 32'(out_valid), 0);
        chk("t8_data",  32'(out_data), 0);
        chk("t8_idx",   32'(out_idx), 0);
        chk("t8_last",  32'(out_last), 0);
        chk("t8_ovf",   32'(overflow), 0);
        chk("t8_done",  32'(done), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t8_nodone", 32'(done), 0);
        go(8'd4, 8'd0, 8'd1, 1'b1);
        wait_valid(c);
        chk("t8_lat", 32'(c), 1);
        for (int i = 0; i < 5; i++) begin
            chk("t8_data", 32'(out_data), 32'(fib[i]));
            chk("t8_idx",  32'(out_idx), 32'(i));
            chk("t8_last", 32'(out_last), (i == 4) ? 1 : 0);
            tick();
        end
        chk("t8_end", 32'(done), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
